qu_boot_loader: RTL and testbench



---
 rtl/qu_boot_loader_pkg.sv | 34 +++
 rtl/qu_boot_loader_if.sv | 39 +++
 rtl/qu_boot_loader_boot_byte_assembler.sv | 43 ++++
 rtl/qu_boot_loader.sv | 170 +++++++++++++++++
 tb/tb_qu_boot_loader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qu_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qu_common (package)
//  Purpose  : Shared types and constants for the Qu boot loader and its
//             neighbours: boot FSM state encoding, start-of-image byte,
//             program-counter width and the word-address type.
//  Revision : 1.0 - initial release
// ============================================================================
package qu_common;

    // Word-address width of the unified program/data memory.
    localparam int QU_PC_WIDTH = 8;

    // Start-of-image marker byte on the boot stream.
    localparam logic [7:0] QU_BOOT_MAGIC = 8'h51;

    typedef logic [QU_PC_WIDTH-1:0] mem_word_addr_t;

    typedef enum logic [2:0] {
        BOOT_IDLE = 3'd0,
        BOOT_LEN  = 3'd1,
        BOOT_DATA = 3'd2,
        BOOT_CHK  = 3'd3,
        BOOT_DONE = 3'd4,
        BOOT_ERR  = 3'd5
    } boot_state_t;

    // The byte stream is accepted in every state except the two terminal ones.
    function automatic logic boot_rx_open(input boot_state_t s);
        return (s != BOOT_DONE) && (s != BOOT_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qu_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : qu_boot_loader_if (interface)
//  Purpose  : Byte-stream input and memory write port of the boot loader.
//  Signals  : rx_valid/rx_data/rx_ready  - byte stream handshake
//             mem_wr_en/mem_addr/mem_wr_data - word write port
//  Modports : master - the loader (consumes stream, drives memory writes)
//             slave  - the environment (sources stream, observes writes)
//  Revision : 1.0 - initial release
// ============================================================================
interface qu_boot_loader_if #(
    parameter int ADDR_WIDTH = qu_common::QU_PC_WIDTH
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wr_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_wr_en,
        output mem_addr,
        output mem_wr_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/qu_boot_loader_boot_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : boot_byte_assembler
//  Purpose  : Collects four bytes little-endian into a 32-bit word.
//             o_word_ready is combinational and fires on the 4th byte, with
//             o_word already holding the complete word, so the caller can
//             register the word on the same edge the last byte is accepted.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_clear         - restart assembly at byte 0
//             i_byte_valid    - byte accepted this cycle
//             i_byte_data     - byte value
//             o_word          - assembled word (valid when o_word_ready)
//             o_word_ready    - 4th byte of a word accepted this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module boot_byte_assembler (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clear,
    input  wire logic        i_byte_valid,
    input  wire logic [7:0]  i_byte_data,
    output logic      [31:0] o_word,
    output logic             o_word_ready
);
    logic [1:0]  r_count;
    // Holds the three earlier bytes; the newest byte enters at the top so
    // byte 0 ends up in the least-significant position.
    logic [23:0] r_shift;

    assign o_word       = {i_byte_data, r_shift};
    assign o_word_ready = i_byte_valid && (r_count == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_byte_valid) begin
            r_count <= r_count + 2'd1;
            r_shift <= {i_byte_data, r_shift[23:8]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/qu_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : qu_boot_loader
//  Purpose  : Receives a program image as a byte stream (MAGIC, 4-byte
//             little-endian word count N, N little-endian data words and,
//             with QU_BOOT_CHECKSUM_EN defined, one XOR checksum byte over
//             the data bytes), writes it word by word into program memory
//             and holds the core in reset until the image is loaded.
//  Ports    : clk, rst  - clock, synchronous active-high reset
//             bus       - qu_boot_loader_if.master (stream in, memory write)
//             core_rst  - core reset, released only on successful load
//             done      - image loaded (sticky until rst)
//             error     - load failed (sticky until rst)
//  Options  : QU_BOOT_CHECKSUM_EN - adds the CHK state and checksum byte
//  Revision : 1.0 - initial release
// ============================================================================
module qu_boot_loader
    import qu_common::*;
#(
    parameter int         ADDR_WIDTH = QU_PC_WIDTH,
    parameter logic [7:0] MAGIC      = QU_BOOT_MAGIC
) (
    input  wire logic          clk,
    input  wire logic          rst,
    qu_boot_loader_if.master   bus,
    output logic               core_rst,
    output logic               done,
    output logic               error
);
    // Largest legal word count is the full memory capacity.
    localparam logic [32:0] c_capacity = 33'd1 << ADDR_WIDTH;

`ifdef QU_BOOT_CHECKSUM_EN
    localparam boot_state_t c_end_state = BOOT_CHK;
`else
    localparam boot_state_t c_end_state = BOOT_DONE;
`endif

    boot_state_t           r_state;
    boot_state_t           w_state_nxt;
    logic                  r_rx_ready;
    logic                  r_mem_wr_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wr_data;
    logic                  r_core_rst;
    logic                  r_done;
    logic                  r_error;
    // One bit wider than the address so N == capacity is representable.
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic [ADDR_WIDTH:0]   r_word_total;
    logic [ADDR_WIDTH:0]   w_word_cnt_inc;
`ifdef QU_BOOT_CHECKSUM_EN
    logic [7:0]            r_checksum;
`endif

    logic                  w_accept;
    logic                  w_asm_valid;
    logic                  w_asm_clear;
    logic [31:0]           w_word;
    logic                  w_word_ready;

    assign w_accept       = bus.rx_valid && r_rx_ready;
    assign w_asm_valid    = w_accept && ((r_state == BOOT_LEN) || (r_state == BOOT_DATA));
    // Realign the assembler to byte 0 while waiting for a header.
    assign w_asm_clear    = (r_state == BOOT_IDLE);
    assign w_word_cnt_inc = r_word_cnt + 1'b1;

    boot_byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_asm_clear),
        .i_byte_valid (w_asm_valid),
        .i_byte_data  (bus.rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT_IDLE: begin
                if (w_accept && (bus.rx_data == MAGIC)) begin
                    w_state_nxt = BOOT_LEN;
                end
            end
            BOOT_LEN: begin
                if (w_word_ready) begin
                    if ({1'b0, w_word} > c_capacity) begin
                        w_state_nxt = BOOT_ERR;
                    end else if (w_word == 32'd0) begin
                        w_state_nxt = c_end_state;
                    end else begin
                        w_state_nxt = BOOT_DATA;
                    end
                end
            end
            BOOT_DATA: begin
                if (w_word_ready && (w_word_cnt_inc == r_word_total)) begin
                    w_state_nxt = c_end_state;
                end
            end
`ifdef QU_BOOT_CHECKSUM_EN
            BOOT_CHK: begin
                if (w_accept) begin
                    w_state_nxt = (bus.rx_data == r_checksum) ? BOOT_DONE : BOOT_ERR;
                end
            end
`endif
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT_IDLE;
            r_rx_ready    <= 1'b1;
            r_mem_wr_en   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= 32'd0;
            r_core_rst    <= 1'b1;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_word_cnt    <= '0;
            r_word_total  <= '0;
`ifdef QU_BOOT_CHECKSUM_EN
            r_checksum    <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            // Status outputs follow the next state so they change together
            // with the state register.
            r_rx_ready  <= boot_rx_open(w_state_nxt);
            r_core_rst  <= (w_state_nxt != BOOT_DONE);
            r_done      <= (w_state_nxt == BOOT_DONE);
            r_error     <= (w_state_nxt == BOOT_ERR);
            r_mem_wr_en <= 1'b0;

            if ((r_state == BOOT_LEN) && w_word_ready) begin
                r_word_total <= w_word[ADDR_WIDTH:0];
                r_word_cnt   <= '0;
            end

            if ((r_state == BOOT_DATA) && w_word_ready) begin
                r_mem_wr_en   <= 1'b1;
                r_mem_addr    <= r_word_cnt[ADDR_WIDTH-1:0];
                r_mem_wr_data <= w_word;
                r_word_cnt    <= w_word_cnt_inc;
            end

`ifdef QU_BOOT_CHECKSUM_EN
            if (r_state == BOOT_IDLE) begin
                r_checksum <= 8'd0;
            end else if ((r_state == BOOT_DATA) && w_accept) begin
                r_checksum <= r_checksum ^ bus.rx_data;
            end
`endif
        end
    end

    assign bus.rx_ready    = r_rx_ready;
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_data = r_mem_wr_data;
    assign core_rst        = r_core_rst;
    assign done            = r_done;
    assign error           = r_error;
endmodule
`default_nettype wire

// File: tb/tb_qu_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qu_boot_loader
//  Purpose  : Directed self-checking bench for qu_boot_loader. Two instances
//             share the stimulus: u_dut_a (ADDR_WIDTH=8) and u_dut_b
//             (ADDR_WIDTH=4, for overflow and full-capacity images); sel
//             picks which one receives the stream and is observed.
//  Options  : QU_BOOT_CHECKSUM_EN - sends checksum bytes, adds bad-checksum case
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_qu_boot_loader;
    import qu_common::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_valid;
    logic [7:0] tb_data;
    logic       sel;
    bit         gap_mode;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    qu_boot_loader_if #(.ADDR_WIDTH(8)) if_a ();
    qu_boot_loader_if #(.ADDR_WIDTH(4)) if_b ();

    logic core_rst_a, done_a, error_a;
    logic core_rst_b, done_b, error_b;

    assign if_a.rx_valid = tb_valid && !sel;
    assign if_a.rx_data  = tb_data;
    assign if_b.rx_valid = tb_valid && sel;
    assign if_b.rx_data  = tb_data;

    qu_boot_loader #(.ADDR_WIDTH(8), .MAGIC(8'h51)) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a),
        .core_rst(core_rst_a), .done(done_a), .error(error_a)
    );

    qu_boot_loader #(.ADDR_WIDTH(4), .MAGIC(8'h51)) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b),
        .core_rst(core_rst_b), .done(done_b), .error(error_b)
    );

    // Observed-instance view
    logic        cur_ready, cur_wr_en, cur_core_rst, cur_done, cur_error;
    logic [31:0] cur_addr, cur_data;
    assign cur_ready    = sel ? if_b.rx_ready    : if_a.rx_ready;
    assign cur_wr_en    = sel ? if_b.mem_wr_en   : if_a.mem_wr_en;
    assign cur_addr     = sel ? 32'(if_b.mem_addr) : 32'(if_a.mem_addr);
    assign cur_data     = sel ? if_b.mem_wr_data : if_a.mem_wr_data;
    assign cur_core_rst = sel ? core_rst_b : core_rst_a;
    assign cur_done     = sel ? done_b     : done_a;
    assign cur_error    = sel ? error_b    : error_a;

    // Write log: every mem_wr_en cycle must directly follow an edge on which
    // a byte was accepted (the 4th byte of that word).
    int          wr_n;
    int          bad_timing;
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    logic        acc_edge;

    always @(posedge clk) acc_edge <= tb_valid && cur_ready && !rst;

    always @(negedge clk) begin
        if (rst) begin
            wr_n       <= 0;
            bad_timing <= 0;
        end else if (cur_wr_en) begin
            if (wr_n < 32) begin
                wr_addr[wr_n] <= cur_addr;
                wr_data[wr_n] <= cur_data;
            end
            wr_n <= wr_n + 1;
            if (!acc_edge) bad_timing <= bad_timing + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic s);
        @(negedge clk);
        tb_valid = 1'b0;
        rst      = 1'b1;
        sel      = s;
        gap_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        if (gap_mode) begin
            tb_valid = 1'b0;
            @(negedge clk);
        end
        tb_valid = 1'b1;
        tb_data  = b;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic finish_stream;
        @(negedge clk);
        tb_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_nominal(input logic [7:0] chk_byte);
        send_byte(8'h51);
        send_word(32'd2);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
`ifdef QU_BOOT_CHECKSUM_EN
        send_byte(chk_byte);
`else
        if (chk_byte == 8'hFF) send_byte(8'h00);   // never true for callers; keeps arg used
`endif
        finish_stream();
    endtask

    task automatic chk_reset_state(input string pfx);
        chk_eq({pfx, " rx_ready"},  32'(cur_ready),    32'd1);
        chk_eq({pfx, " wr_en"},     32'(cur_wr_en),    32'd0);
        chk_eq({pfx, " addr"},      cur_addr,          32'd0);
        chk_eq({pfx, " wr_data"},   cur_data,          32'd0);
        chk_eq({pfx, " core_rst"},  32'(cur_core_rst), 32'd1);
        chk_eq({pfx, " done"},      32'(cur_done),     32'd0);
        chk_eq({pfx, " error"},     32'(cur_error),    32'd0);
    endtask

    task automatic chk_end(input string pfx, input logic exp_done, input logic exp_err);
        chk_eq({pfx, " done"},     32'(cur_done),     32'(exp_done));
        chk_eq({pfx, " error"},    32'(cur_error),    32'(exp_err));
        chk_eq({pfx, " core_rst"}, 32'(cur_core_rst), 32'(!exp_done));
        chk_eq({pfx, " rx_ready"}, 32'(cur_ready),    32'(!(exp_done || exp_err)));
    endtask

    task automatic chk_nominal_writes(input string pfx);
        chk_eq({pfx, " wr count"},  32'(wr_n),       32'd2);
        chk_eq({pfx, " wr0 addr"},  wr_addr[0],      32'd0);
        chk_eq({pfx, " wr0 data"},  wr_data[0],      32'h1234_5678);
        chk_eq({pfx, " wr1 addr"},  wr_addr[1],      32'd1);
        chk_eq({pfx, " wr1 data"},  wr_data[1],      32'hDEAD_BEEF);
        chk_eq({pfx, " wr timing"}, 32'(bad_timing), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        tb_valid = 1'b0;
        tb_data  = 8'h00;
        sel      = 1'b0;
        gap_mode = 1'b0;

        // Reset state
        do_reset(1'b0);
        chk_reset_state("reset");

        // 1. Nominal load; data-byte XOR = 0x2A
        send_nominal(8'h2A);
        chk_nominal_writes("nominal");
        chk_end("nominal", 1'b1, 1'b0);

`ifdef QU_BOOT_CHECKSUM_EN
        // 2. Bad checksum
        do_reset(1'b0);
        send_nominal(8'h01);
        chk_end("badchk", 1'b0, 1'b1);
`endif

        // 3. Length overflow on the 16-word instance
        do_reset(1'b1);
        send_byte(8'h51);
        send_word(32'h0000_0011);
        @(negedge clk);
        tb_valid = 1'b0;
        chk_eq("ovf error next cycle", 32'(cur_error), 32'd1);
        for (int i = 0; i < 6; i++) send_byte(8'h51);   // ignored in ERR
        finish_stream();
        chk_end("ovf", 1'b0, 1'b1);
        chk_eq("ovf wr count", 32'(wr_n), 32'd0);

        // 4. Garbage before header, gaps on every byte
        do_reset(1'b0);
        gap_mode = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_nominal(8'h2A);
        chk_nominal_writes("gaps");
        chk_end("gaps", 1'b1, 1'b0);

        // 5a. Zero-length image
        do_reset(1'b0);
        send_byte(8'h51);
        send_word(32'd0);
`ifdef QU_BOOT_CHECKSUM_EN
        send_byte(8'h00);
`endif
        finish_stream();
        chk_end("zero", 1'b1, 1'b0);
        chk_eq("zero wr count", 32'(wr_n), 32'd0);

        // 5b. Full capacity (16 words) on the 4-bit instance; word i = A500_00ii,
        // XOR over all data bytes is 0
        do_reset(1'b1);
        send_byte(8'h51);
        send_word(32'd16);
        for (int i = 0; i < 16; i++) send_word(32'hA500_0000 | 32'(i));
`ifdef QU_BOOT_CHECKSUM_EN
        send_byte(8'h00);
`endif
        finish_stream();
        chk_eq("full wr count", 32'(wr_n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk_eq($sformatf("full wr%0d addr", i), wr_addr[i], 32'(i));
            chk_eq($sformatf("full wr%0d data", i), wr_data[i], 32'hA500_0000 | 32'(i));
        end
        chk_eq("full wr timing", 32'(bad_timing), 32'd0);
        chk_end("full", 1'b1, 1'b0);

        // 6. Reset after 5 data bytes, then a fresh one-word image (XOR = 0x44)
        do_reset(1'b0);
        send_byte(8'h51);
        send_word(32'd2);
        send_word(32'h1234_5678);
        send_byte(8'hEF);
        do_reset(1'b0);
        chk_reset_state("midrst");
        send_byte(8'h51);
        send_word(32'd1);
        send_word(32'h1122_3344);
`ifdef QU_BOOT_CHECKSUM_EN
        send_byte(8'h44);
`endif
        finish_stream();
        chk_eq("reload wr count", 32'(wr_n),  32'd1);
        chk_eq("reload wr0 addr", wr_addr[0], 32'd0);
        chk_eq("reload wr0 data", wr_data[0], 32'h1122_3344);
        chk_end("reload", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
